// File: rtl/dtc_pipe.sv
// Pipelined binary decision-tree classifier: one tree level per stage, heap-indexed
// node table, leaf labels looked up from the final stage's node index.
module dtc_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4,
    localparam int FW = (IN_W > 1) ? $clog2(IN_W) : 1,
    localparam int CW = (OUT_W > FW) ? OUT_W : FW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  inp,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] outp,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cfg_we,
    input  logic [DEPTH:0]   cfg_addr,
    input  logic [CW-1:0]    cfg_data,
    output logic             cfg_err,
    output logic             busy,
    output logic [15:0]      class_cnt
);

    localparam int NW = DEPTH + 1;
    localparam int NN = 1 << DEPTH;
    localparam logic [FW:0] IN_LIM = (FW + 1)'(IN_W);

    logic [FW-1:0]    feat_r  [NN];
    logic [OUT_W-1:0] label_r [NN];
    logic [IN_W-1:0]  data_r  [1:DEPTH];
    logic [NW-1:0]    node_r  [1:DEPTH];
    logic [DEPTH:1]   valid_r;
    logic             cfg_err_r;
    logic [15:0]      cnt_r;

    logic [NW-1:0]    src_node_s [DEPTH];
    logic [IN_W-1:0]  src_data_s [DEPTH];
    logic [NW-1:0]    nxt_node_s [1:DEPTH];
    logic             adv_s;
    logic             busy_s;
    logic             cfg_ok_s;

    assign adv_s    = !valid_r[DEPTH] || out_ready;
    assign busy_s   = |valid_r;
    assign cfg_ok_s = cfg_we && !busy_s && !in_valid && (cfg_addr != '0);

    // Per-level decision: each stage walks one edge down the tree using its own sample
    always_comb begin
        logic [FW-1:0] sel;
        logic          bit_s;
        sel           = '0;
        bit_s         = 1'b0;
        src_node_s[0] = NW'(1);
        src_data_s[0] = inp;
        for (int k = 1; k < DEPTH; k++) begin
            src_node_s[k] = node_r[k];
            src_data_s[k] = data_r[k];
        end
        for (int k = 0; k < DEPTH; k++) begin
            sel   = feat_r[src_node_s[k][DEPTH-1:0]];
            // Selects past the top of the feature vector read as a 0 bit
            bit_s = ({1'b0, sel} < IN_LIM) ? src_data_s[k][sel] : 1'b0;
            nxt_node_s[k+1] = {src_node_s[k][NW-2:0], bit_s};
        end
    end

    // Stage registers: all stages shift together whenever the output can drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                data_r[k] <= '0;
                node_r[k] <= '0;
            end
        end else if (adv_s) begin
            valid_r[1] <= in_valid;
            data_r[1]  <= inp;
            node_r[1]  <= nxt_node_s[1];
            for (int k = 2; k <= DEPTH; k++) begin
                valid_r[k] <= valid_r[k-1];
                data_r[k]  <= data_r[k-1];
                node_r[k]  <= nxt_node_s[k];
            end
        end
    end

    // Node/leaf table: writable only while the pipeline is idle and no sample is offered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NN; i++) begin
                feat_r[i]  <= '0;
                label_r[i] <= '0;
            end
        end else if (cfg_ok_s) begin
            if (cfg_addr[DEPTH]) begin
                label_r[cfg_addr[DEPTH-1:0]] <= cfg_data[OUT_W-1:0];
            end else begin
                feat_r[cfg_addr[DEPTH-1:0]] <= cfg_data[FW-1:0];
            end
        end
    end

    // Rejected-write flag and saturating delivered-result counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_r <= 1'b0;
            cnt_r     <= 16'd0;
        end else begin
            cfg_err_r <= cfg_we && !cfg_ok_s;
            if (valid_r[DEPTH] && out_ready && (cnt_r != 16'hFFFF)) begin
                cnt_r <= cnt_r + 16'd1;
            end
        end
    end

    assign outp      = label_r[node_r[DEPTH][DEPTH-1:0]];
    assign out_valid = valid_r[DEPTH];
    assign in_ready  = adv_s;
    assign busy      = busy_s;
    assign cfg_err   = cfg_err_r;
    assign class_cnt = cnt_r;

endmodule

// File: doc/dtc_pipe.md
DTC_PIPE -- requirements
Module: dtc_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 8, giving the feature vector width.
REQ-002 The block SHALL have parameter OUT_W, default 8, giving the class label width.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the tree depth (decision levels), legal range 1..8.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-006 The block SHALL have port inp, input, IN_W, the feature vector.
REQ-007 The block SHALL have port in_valid, input, 1, which qualifies inp.
REQ-008 The block SHALL have port in_ready, output, 1, which indicates the block can accept inp.
REQ-009 The block SHALL have port outp, output, OUT_W, the class label.
REQ-010 The block SHALL have port out_valid, output, 1, which qualifies outp.
REQ-011 The block SHALL have port out_ready, input, 1, the downstream accept.
REQ-012 The block SHALL have port cfg_we, input, 1, the table write strobe.
REQ-013 The block SHALL have port cfg_addr, input, DEPTH+1, the node index.
REQ-014 The block SHALL have port cfg_data, input, max(OUT_W, clog2(IN_W)), the feature select or leaf label.
REQ-015 The block SHALL have port cfg_err, output, 1, a one-cycle pulse on a rejected write.
REQ-016 The block SHALL have port busy, output, 1, high while any sample is in the pipeline.
REQ-017 The block SHALL have port class_cnt, output, 16, a saturating count of delivered results.

Function
REQ-018 The tree SHALL use heap indexing: root = 1, internal nodes 1..2^DEPTH-1, leaves 2^DEPTH..2^(DEPTH+1)-1, and cfg_addr 0 SHALL be unused.
REQ-019 Each internal node n SHALL store a feature select f(n) of clog2(IN_W) bits; the next node SHALL be 2n+inp[f(n)].
REQ-020 Each leaf SHALL store an OUT_W-bit label, and outp SHALL equal the label of the leaf reached.
REQ-021 A feature select >= IN_W SHALL read as bit value 0.
REQ-022 The pipeline SHALL have DEPTH stages, with stage k holding the captured inp, the node index after level k, and a valid bit.
REQ-023 Global advance SHALL be adv = !out_valid || out_ready; all stages SHALL shift when adv is high and hold otherwise.
REQ-024 in_ready SHALL equal adv, and a sample SHALL be accepted on an edge where in_valid && in_ready.
REQ-025 A sample accepted at the end of cycle t SHALL present out_valid in cycle t+DEPTH when there is no stall, giving a latency of DEPTH cycles and a throughput of 1 per cycle.
REQ-026 Bubbles SHALL shift with the data and SHALL NOT be compressed.
REQ-027 While out_valid && !out_ready, outp, out_valid and all stages SHALL hold stable.
REQ-028 The feature vector SHALL travel with its sample, so that stage k evaluates node f(n) on the sample's own inp.
REQ-029 busy SHALL equal the OR of all stage valid bits.
REQ-030 A cfg_we with busy==0 && in_valid==0 SHALL write cfg_data into entry cfg_addr at that edge; internal nodes SHALL take the low clog2(IN_W) bits and leaves the low OUT_W bits.
REQ-031 A cfg_we with busy==1, in_valid==1, or cfg_addr==0 SHALL be ignored, and cfg_err SHALL pulse high for exactly the following cycle.
REQ-032 When cfg_we and in_valid coincide, the sample SHALL be accepted (if in_ready) and the write SHALL be rejected.
REQ-033 class_cnt SHALL increment on each edge with out_valid && out_ready and SHALL saturate at 0xFFFF.
REQ-034 The block SHALL contain no combinational path from inp to outp.

Reset
REQ-035 On rst high, all stage valid bits, out_valid, cfg_err, busy and class_cnt SHALL go to 0 immediately and asynchronously.
REQ-036 On reset, all feature selects and all leaf labels SHALL be cleared to 0, making outp 0.
REQ-037 in_ready SHALL be 1 during and after reset.
REQ-038 Reset during operation SHALL discard in-flight samples with no output produced for them.
REQ-039 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-040 The bench SHALL cover this case (DEPTH=4): after reset, write node 1..15 = 0, leaf 16 = 0x11, leaf 31 = 0xA5; send inp=0x01 -> outp=0xA5, out_valid in cycle t+4; then inp=0x00 -> 0x11.
REQ-041 The bench SHALL cover this case: streaming 16 samples back-to-back with out_ready=1 -> 16 results on consecutive cycles, in order, with class_cnt=16.
REQ-042 The bench SHALL cover this case: holding out_ready=0 for 3 cycles with a full pipeline -> in_ready=0 and outp/out_valid stable, with no loss or duplication after release.
REQ-043 The bench SHALL cover this case: cfg_we while busy=1 -> cfg_err pulses for 1 cycle, the table is unchanged, and later results use the old labels.
REQ-044 The bench SHALL cover this case: rst asserted asynchronously with 3 samples in flight -> out_valid=0 at once, the table is cleared, and a sample sent after release yields outp=0x00.
REQ-045 The bench SHALL cover this case: class_cnt forced to 0xFFFF via 65535 results -> a further result leaves it at 0xFFFF.
